// File: rtl/ysyx_22041071_mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM arbiter in front of the single-ported RAMHelper.
package ysyx_22041071_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  localparam logic [63:0] DEF_MEM_BASE   = 64'h8000_0000;
  localparam logic [63:0] DEF_MEM_SIZE   = 64'h0800_0000;
  localparam int          DEF_MAX_STREAK = 4;

  // The lower-bound test also rejects addresses whose subtraction would wrap.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    logic [63:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset < size);
  endfunction

endpackage

// File: rtl/ysyx_22041071_arb_pick.sv
// Grant selection for the arbiter: MEM wins unless IF has waited through MAX_STREAK MEM grants.
module ysyx_22041071_arb_pick
  import ysyx_22041071_mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_req_valid,
  input  logic mem_req_valid,
  output logic grant_if,
  output logic grant_mem
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak;
  logic          if_starved;

  // NOTE: every output gets a value before any condition, so no latch can be inferred.
  always_comb begin
    if_starved = if_req_valid && (streak == SW'(MAX_STREAK));
    grant_mem  = idle && mem_req_valid && !if_starved;
    grant_if   = idle && if_req_valid && !grant_mem;
  end

  // A grant is the handshake itself: ready is only raised while the side is valid.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (!if_req_valid || grant_if) begin
      streak <= '0;
    end else if (grant_mem) begin
      streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/ysyx_22041071_mem_arbiter.sv
// Shares one RAMHelper port between instruction fetch and load/store, one access in flight.
module ysyx_22041071_mem_arbiter
  import ysyx_22041071_mem_arbiter_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [63:0] MEM_SIZE   = DEF_MEM_SIZE,
  parameter int          MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_ins,
  output logic        if_rsp_err,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic        mem_req_wen,
  input  logic [63:0] mem_req_addr,
  input  logic [63:0] mem_req_wdata,
  input  logic [63:0] mem_req_wmask,
  output logic        mem_rsp_valid,
  input  logic        mem_rsp_ready,
  output logic [63:0] mem_rsp_rdata,
  output logic        mem_rsp_err,
  output logic        ram_en,
  output logic        ram_wen,
  output logic [63:0] ram_idx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q;
  logic        wen_q, err_q, sel_hi_q, rsp_err_q;
  logic [63:0] idx_q, wdata_q, wmask_q, rdata_q;

  logic        grant_if, grant_mem, req_fire, rsp_fire;
  logic [63:0] req_addr;

  ysyx_22041071_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .clk          (clk),
    .reset        (reset),
    .idle         (state_q == ARB_IDLE),
    .if_req_valid (if_req_valid),
    .mem_req_valid(mem_req_valid),
    .grant_if     (grant_if),
    .grant_mem    (grant_mem)
  );

  always_comb begin
    req_fire      = grant_if || grant_mem;
    req_addr      = grant_if ? if_req_addr : mem_req_addr;
    if_req_ready  = grant_if;
    mem_req_ready = grant_mem;
    if_rsp_valid  = (state_q == ARB_RESP) && (owner_q == OWNER_IF);
    mem_rsp_valid = (state_q == ARB_RESP) && (owner_q == OWNER_MEM);
    rsp_fire      = (if_rsp_valid && if_rsp_ready) || (mem_rsp_valid && mem_rsp_ready);
    // Strobes are gated by reset so an interrupted store never reaches the RAM.
    ram_en        = (state_q == ARB_ACCESS) && !reset && !err_q && !wen_q;
    ram_wen       = (state_q == ARB_ACCESS) && !reset && !err_q && wen_q;
    ram_idx       = idx_q;
    ram_wdata     = wdata_q;
    ram_wmask     = wmask_q;
    if_rsp_ins    = sel_hi_q ? rdata_q[63:32] : rdata_q[31:0];
    if_rsp_err    = rsp_err_q;
    mem_rsp_rdata = rdata_q;
    mem_rsp_err   = rsp_err_q;

    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (req_fire) state_d = ARB_ACCESS;
      ARB_ACCESS: state_d = ARB_RESP;
      ARB_RESP:   if (rsp_fire) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_IF;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
      sel_hi_q  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        owner_q  <= grant_mem ? OWNER_MEM : OWNER_IF;
        wen_q    <= grant_mem && mem_req_wen;
        err_q    <= !addr_in_range(req_addr, MEM_BASE, MEM_SIZE);
        sel_hi_q <= req_addr[2];
        idx_q    <= (req_addr - MEM_BASE) >> 3;
        wdata_q  <= grant_mem ? mem_req_wdata : '0;
        wmask_q  <= grant_mem ? mem_req_wmask : '0;
      end
      // Response data is frozen here and stays put however long the consumer stalls.
      if (state_q == ARB_ACCESS) begin
        rdata_q   <= (err_q || wen_q) ? '0 : ram_rdata;
        rsp_err_q <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_mem_arbiter.sv
// Directed bench for the IF/MEM arbiter: latency, store strobe, errors, stalls, fairness, reset.
module tb_ysyx_22041071_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [63:0] if_req_addr;
  logic [31:0] if_rsp_ins;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask, mem_rsp_rdata;
  logic        ram_en, ram_wen;
  logic [63:0] ram_idx, ram_wdata, ram_wmask, ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22041071_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_ins   (if_rsp_ins),
    .if_rsp_err   (if_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_wen  (mem_req_wen),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err  (mem_rsp_err),
    .ram_en       (ram_en),
    .ram_wen      (ram_wen),
    .ram_idx      (ram_idx),
    .ram_wdata    (ram_wdata),
    .ram_wmask    (ram_wmask),
    .ram_rdata    (ram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] if_pat;

  initial begin
    reset         = 1'b1;
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    if_rsp_ready  = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wen   = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    mem_rsp_ready = 1'b0;
    ram_rdata     = '0;
    if_pat        = 10'b10_0001_0000;

    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_if_req_ready", 64'(if_req_ready), 64'd0);
    check("rst_mem_req_ready", 64'(mem_req_ready), 64'd0);
    check("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    check("rst_mem_rsp_valid", 64'(mem_rsp_valid), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_wen", 64'(ram_wen), 64'd0);
    check("rst_mem_rdata", mem_rsp_rdata, 64'd0);
    check("rst_mem_err", 64'(mem_rsp_err), 64'd0);

    // IF fetch of the upper word half, response two cycles after handshake
    tick();
    ram_rdata    = 64'h1111_2222_3333_4444;
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0004;
    @(negedge clk);
    check("if_req_ready", 64'(if_req_ready), 64'd1);
    check("if_only_mem_ready", 64'(mem_req_ready), 64'd0);
    tick();
    if_req_valid = 1'b0;
    @(negedge clk);
    check("if_access_ram_en", 64'(ram_en), 64'd1);
    check("if_access_ram_wen", 64'(ram_wen), 64'd0);
    check("if_access_idx", ram_idx, 64'd0);
    check("if_access_no_rsp", 64'(if_rsp_valid), 64'd0);
    tick();
    ram_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    @(negedge clk);
    check("if_rsp_valid", 64'(if_rsp_valid), 64'd1);
    check("if_rsp_ins", 64'(if_rsp_ins), 64'h1111_2222);
    check("if_rsp_err", 64'(if_rsp_err), 64'd0);
    check("if_rsp_ram_en_off", 64'(ram_en), 64'd0);
    tick();
    @(negedge clk);
    check("if_rsp_hold_valid", 64'(if_rsp_valid), 64'd1);
    check("if_rsp_hold_ins", 64'(if_rsp_ins), 64'h1111_2222);
    if_rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("if_rsp_done", 64'(if_rsp_valid), 64'd0);

    // MEM store: single write strobe at index 2, ack carries zero data
    mem_rsp_ready = 1'b1;
    tick();
    mem_req_valid = 1'b1;
    mem_req_wen   = 1'b1;
    mem_req_addr  = 64'h8000_0010;
    mem_req_wdata = 64'hAB;
    mem_req_wmask = 64'hFF;
    @(negedge clk);
    check("st_req_ready", 64'(mem_req_ready), 64'd1);
    tick();
    mem_req_valid = 1'b0;
    @(negedge clk);
    check("st_ram_wen", 64'(ram_wen), 64'd1);
    check("st_ram_en", 64'(ram_en), 64'd0);
    check("st_ram_idx", ram_idx, 64'd2);
    check("st_ram_wdata", ram_wdata, 64'hAB);
    check("st_ram_wmask", ram_wmask, 64'hFF);
    tick();
    @(negedge clk);
    check("st_wen_one_cycle", 64'(ram_wen), 64'd0);
    check("st_rsp_valid", 64'(mem_rsp_valid), 64'd1);
    check("st_rsp_rdata", mem_rsp_rdata, 64'd0);
    check("st_rsp_err", 64'(mem_rsp_err), 64'd0);
    tick();

    // Load below the RAM window: no strobe, error response with zero data
    mem_req_valid = 1'b1;
    mem_req_wen   = 1'b0;
    mem_req_addr  = 64'h7FFF_FFF8;
    ram_rdata     = 64'h5555_6666_7777_8888;
    tick();
    mem_req_valid = 1'b0;
    @(negedge clk);
    check("err_no_ram_en", 64'(ram_en), 64'd0);
    tick();
    @(negedge clk);
    check("err_rsp_valid", 64'(mem_rsp_valid), 64'd1);
    check("err_rsp_err", 64'(mem_rsp_err), 64'd1);
    check("err_rsp_rdata", mem_rsp_rdata, 64'd0);
    tick();

    // Load with the consumer stalled while both sides keep requesting
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_addr  = 64'h8000_0008;
    ram_rdata     = 64'h0123_4567_89AB_CDEF;
    tick();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0000;
    tick();
    ram_rdata = 64'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 64'(mem_rsp_valid), 64'd1);
      check("stall_rsp_rdata", mem_rsp_rdata, 64'h0123_4567_89AB_CDEF);
      check("stall_if_ready", 64'(if_req_ready), 64'd0);
      check("stall_mem_ready", 64'(mem_req_ready), 64'd0);
      tick();
    end
    mem_rsp_ready = 1'b1;
    if_rsp_ready  = 1'b1;
    tick();

    // Both sides valid every cycle: M,M,M,M,I,M,M,M,M,I
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("grant%0d_if", i), 64'(if_req_ready), 64'(if_pat[i]));
      check($sformatf("grant%0d_mem", i), 64'(mem_req_ready), 64'(!if_pat[i]));
      tick();
      tick();
      tick();
    end
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    tick();

    // Reset lands during the ACCESS cycle of a store
    mem_req_valid = 1'b1;
    mem_req_wen   = 1'b1;
    mem_req_addr  = 64'h8000_0018;
    @(negedge clk);
    check("rst_st_req_ready", 64'(mem_req_ready), 64'd1);
    tick();
    mem_req_valid = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    check("rst_st_ram_wen", 64'(ram_wen), 64'd0);
    tick();
    reset         = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_wen   = 1'b0;
    mem_req_addr  = 64'h8000_0000;
    @(negedge clk);
    check("rst_st_no_rsp", 64'(mem_rsp_valid), 64'd0);
    check("rst_st_idle_ready", 64'(mem_req_ready), 64'd1);
    check("rst_st_ram_wen_after", 64'(ram_wen), 64'd0);
    tick();
    mem_req_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
